// File: rtl/data_mem_hs.sv
// data_mem_hs: handshaked data memory for the RISC-V load/store unit.
// One request per cycle over valid/ready, response one cycle after acceptance,
// held stable under back-pressure. Byte-lane RAM with per-byte write enables.
// Misaligned accesses and illegal funct3 encodings return rsp_err with no side
// effect. Optional build macro DMEM_BOUNDS_CHECK_EN: addresses at or above
// MEM_DEPTH*NBYTES are rejected instead of wrapping onto low rows.
module data_mem_hs #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int OFF    = $clog2(NBYTES);
  localparam int IDX_W  = $clog2(MEM_DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  // Request decode
  logic [1:0]            size;
  logic [OFF-1:0]        lane_off;
  logic [IDX_W-1:0]      row_idx;
  logic                  f3_bad;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  req_err;
  logic                  accept;
  logic                  wr_en;
  logic                  rd_en;
  logic [3:0]            acc_bytes;
  logic [NBYTES-1:0]     byte_en;
  logic [DATA_WIDTH-1:0] wdata_lane;
  logic [DATA_WIDTH-1:0] rd_row;

  // Response state
  state_t                state;
  logic                  err_q;
  logic                  load_q;
  logic                  unsgn_q;
  logic [1:0]            size_q;
  logic [OFF-1:0]        off_q;

  // Load extraction
  logic [DATA_WIDTH-1:0] field;
  logic [DATA_WIDTH-1:0] mask;
  logic [DATA_WIDTH-1:0] ext;
  logic                  sign_bit;
  int                    bits;

  assign rsp_valid = (state == RESP);
  assign rsp_err   = err_q;
  // A slot frees up in the same cycle the consumer takes the current response.
  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;

  // Classify the incoming request: size, lane, row, and any reason to reject it.
  always_comb begin
    size     = req_funct3[1:0];
    lane_off = req_addr[OFF-1:0];
    row_idx  = req_addr[OFF +: IDX_W];

    f3_bad = 1'b0;
    if (req_funct3 == 3'b111) f3_bad = 1'b1;
    if (req_we && req_funct3[2]) f3_bad = 1'b1;
    if ((DATA_WIDTH == 32) && (req_funct3[1:0] == 2'b11)) f3_bad = 1'b1;
    if ((DATA_WIDTH == 32) && (req_funct3 == 3'b110)) f3_bad = 1'b1;

    case (size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      default: misaligned = |req_addr[2:0];
    endcase

`ifdef DMEM_BOUNDS_CHECK_EN
    out_of_range = (req_addr >> (OFF + IDX_W)) != '0;
`else
    out_of_range = 1'b0;
`endif

    req_err = f3_bad || misaligned || out_of_range;
  end

  assign acc_bytes  = 4'd1 << size;
  assign wdata_lane = req_wdata << {lane_off, 3'b000};
  // rst_n gate keeps the RAM untouched while the block is held in reset.
  assign wr_en      = accept && req_we && !req_err && rst_n;
  assign rd_en      = accept && !req_we && !req_err && rst_n;

  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_lane
      logic [7:0] mem [MEM_DEPTH];
      logic [7:0] rd_byte;

      assign byte_en[gi] = (gi >= int'(lane_off)) &&
                           (gi < int'(lane_off) + int'(acc_bytes));
      assign rd_row[gi*8 +: 8] = rd_byte;

      // Byte-lane RAM: enabled write of this lane, registered read of the row.
      always_ff @(posedge clk) begin
        if (wr_en && byte_en[gi]) begin
          mem[row_idx] <= wdata_lane[gi*8 +: 8];
        end
        if (rd_en) begin
          rd_byte <= mem[row_idx];
        end
      end
    end
  endgenerate

  // Response FSM: capture each accepted request's outcome, hold it until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
      unsgn_q <= 1'b0;
      size_q  <= 2'b00;
      off_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= RESP;
            err_q   <= req_err;
            load_q  <= !req_we && !req_err;
            unsgn_q <= req_funct3[2];
            size_q  <= size;
            off_q   <= lane_off;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            if (accept) begin
              err_q   <= req_err;
              load_q  <= !req_we && !req_err;
              unsgn_q <= req_funct3[2];
              size_q  <= size;
              off_q   <= lane_off;
            end else begin
              state  <= IDLE;
              err_q  <= 1'b0;
              load_q <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shift the addressed field down and sign- or zero-extend it to full width.
  always_comb begin
    field = rd_row >> {off_q, 3'b000};
    bits  = 8 << size_q;
    if (bits >= DATA_WIDTH) begin
      mask     = '1;
      sign_bit = 1'b0;
    end else begin
      mask     = ~({DATA_WIDTH{1'b1}} << bits);
      sign_bit = field[bits-1];
    end
    ext = field & mask;
    if (!unsgn_q && sign_bit) begin
      ext = ext | ~mask;
    end
    rsp_rdata = load_q ? ext : '0;
  end

endmodule

// File: tb/tb_data_mem_hs.sv
// tb_data_mem_hs: directed table-driven checks of data_mem_hs on a 32-bit and a
// 64-bit instance, plus hand-written back-pressure and reset-mid-response cases.
module tb_data_mem_hs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // 32-bit instance
  logic        a_req_valid, a_req_ready, a_req_we;
  logic [2:0]  a_req_funct3;
  logic [31:0] a_req_addr, a_req_wdata;
  logic        a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [31:0] a_rsp_rdata;

  // 64-bit instance
  logic        b_req_valid, b_req_ready, b_req_we;
  logic [2:0]  b_req_funct3;
  logic [31:0] b_req_addr;
  logic [63:0] b_req_wdata;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [63:0] b_rsp_rdata;

  data_mem_hs #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(64)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_funct3(a_req_funct3), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  data_mem_hs #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .MEM_DEPTH(64)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_funct3(b_req_funct3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          wide;
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [63:0] wdata;
    bit          exp_err;
    logic [63:0] exp_rdata;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic void add(input bit wide, input bit we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [63:0] wdata,
                              input bit exp_err, input logic [63:0] exp_rdata,
                              input string name);
    vec_t v;
    v.wide = wide; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_err = exp_err; v.exp_rdata = exp_rdata; v.name = name;
    vecs.push_back(v);
  endfunction

  task automatic set_a(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    a_req_valid  = 1'b1;
    a_req_we     = we;
    a_req_funct3 = f3;
    a_req_addr   = addr;
    a_req_wdata  = wdata;
  endtask

  // Drive one request, take the accept edge, check the response one cycle later.
  task automatic run_vec(input vec_t v);
    logic [63:0] rdata;
    logic        err, valid;
    if (!v.wide) begin
      set_a(v.we, v.f3, v.addr, v.wdata[31:0]);
      #1 check({v.name, " ready"}, {63'd0, a_req_ready}, 64'd1);
    end else begin
      b_req_valid  = 1'b1;
      b_req_we     = v.we;
      b_req_funct3 = v.f3;
      b_req_addr   = v.addr;
      b_req_wdata  = v.wdata;
      #1 check({v.name, " ready"}, {63'd0, b_req_ready}, 64'd1);
    end
    @(posedge clk);
    #1;
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    if (!v.wide) begin
      valid = a_rsp_valid; err = a_rsp_err; rdata = {32'd0, a_rsp_rdata};
    end else begin
      valid = b_rsp_valid; err = b_rsp_err; rdata = b_rsp_rdata;
    end
    $display("[TB] %s: valid=%0d err=%0d rdata=%h", v.name, valid, err, rdata);
    check({v.name, " valid"}, {63'd0, valid}, 64'd1);
    check({v.name, " err"}, {63'd0, err}, {63'd0, v.exp_err});
    check({v.name, " rdata"}, rdata, v.exp_rdata);
  endtask

  initial begin
    bit bc;
`ifdef DMEM_BOUNDS_CHECK_EN
    bc = 1'b1;
`else
    bc = 1'b0;
`endif
    rst_n = 1'b0;
    a_req_valid = 0; a_req_we = 0; a_req_funct3 = 0; a_req_addr = 0; a_req_wdata = 0;
    b_req_valid = 0; b_req_we = 0; b_req_funct3 = 0; b_req_addr = 0; b_req_wdata = 0;
    a_rsp_ready = 1'b1;
    b_rsp_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("reset rsp_valid", {63'd0, a_rsp_valid}, 64'd0);
    check("reset rsp_err", {63'd0, a_rsp_err}, 64'd0);
    check("reset rsp_rdata", {32'd0, a_rsp_rdata}, 64'd0);
    check("reset b rsp_valid", {63'd0, b_rsp_valid}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 32-bit instance
    add(0, 1, 3'b010, 32'h10, 64'h8000_00F1, 0, 64'h0, "SW 0x10");
    add(0, 0, 3'b000, 32'h10, 64'h0, 0, 64'hFFFF_FFF1, "LB 0x10");
    add(0, 0, 3'b100, 32'h13, 64'h0, 0, 64'h0000_0080, "LBU 0x13");
    add(0, 0, 3'b001, 32'h12, 64'h0, 0, 64'hFFFF_8000, "LH 0x12");
    add(0, 0, 3'b101, 32'h12, 64'h0, 0, 64'h0000_8000, "LHU 0x12");
    add(0, 1, 3'b010, 32'h20, 64'h1122_3344, 0, 64'h0, "SW 0x20");
    add(0, 1, 3'b000, 32'h21, 64'h1234_56AA, 0, 64'h0, "SB 0x21");
    add(0, 0, 3'b010, 32'h20, 64'h0, 0, 64'h1122_AA44, "LW 0x20 after SB");
    add(0, 1, 3'b001, 32'h22, 64'h0000_BEEF, 0, 64'h0, "SH 0x22");
    add(0, 0, 3'b010, 32'h20, 64'h0, 0, 64'hBEEF_AA44, "LW 0x20 after SH");
    add(0, 0, 3'b000, 32'h23, 64'h0, 0, 64'hFFFF_FFBE, "LB 0x23");
    add(0, 0, 3'b101, 32'h22, 64'h0, 0, 64'h0000_BEEF, "LHU 0x22");
    add(0, 0, 3'b010, 32'h22, 64'h0, 1, 64'h0, "LW 0x22 misaligned");
    add(0, 0, 3'b001, 32'h01, 64'h0, 1, 64'h0, "LH 0x01 misaligned");
    add(0, 1, 3'b010, 32'h04, 64'hCAFE_F00D, 0, 64'h0, "SW 0x04");
    add(0, 1, 3'b001, 32'h05, 64'h1234, 1, 64'h0, "SH 0x05 misaligned");
    add(0, 0, 3'b010, 32'h04, 64'h0, 0, 64'hCAFE_F00D, "LW 0x04 unchanged");
    add(0, 0, 3'b011, 32'h08, 64'h0, 1, 64'h0, "LD on 32-bit");
    add(0, 0, 3'b110, 32'h04, 64'h0, 1, 64'h0, "LWU on 32-bit");
    add(0, 0, 3'b111, 32'h04, 64'h0, 1, 64'h0, "funct3 111");
    add(0, 1, 3'b100, 32'h04, 64'h5555_5555, 1, 64'h0, "store funct3 100");
    add(0, 0, 3'b010, 32'h04, 64'h0, 0, 64'hCAFE_F00D, "LW 0x04 after bad store");
    add(0, 1, 3'b010, 32'h00, 64'h0102_0304, 0, 64'h0, "SW 0x00");
    add(0, 1, 3'b010, 32'h100, 64'h5A5A_5A5A, bc, 64'h0, "SW 0x100");
    add(0, 0, 3'b010, 32'h00, 64'h0, 0, bc ? 64'h0102_0304 : 64'h5A5A_5A5A, "LW 0x00 alias");
    add(0, 0, 3'b010, 32'h100, 64'h0, bc, bc ? 64'h0 : 64'h5A5A_5A5A, "LW 0x100");
    // 64-bit instance
    add(1, 1, 3'b011, 32'h08, 64'h8765_4321_0FED_CBA9, 0, 64'h0, "SD 0x08");
    add(1, 0, 3'b110, 32'h0C, 64'h0, 0, 64'h0000_0000_8765_4321, "LWU 0x0C");
    add(1, 0, 3'b010, 32'h0C, 64'h0, 0, 64'hFFFF_FFFF_8765_4321, "LW 0x0C");
    add(1, 0, 3'b110, 32'h08, 64'h0, 0, 64'h0000_0000_0FED_CBA9, "LWU 0x08");
    add(1, 0, 3'b011, 32'h08, 64'h0, 0, 64'h8765_4321_0FED_CBA9, "LD 0x08");
    add(1, 0, 3'b011, 32'h208, 64'h0, bc, bc ? 64'h0 : 64'h8765_4321_0FED_CBA9, "LD 0x208");
    add(1, 0, 3'b011, 32'h0C, 64'h0, 1, 64'h0, "LD 0x0C misaligned");
    add(1, 0, 3'b100, 32'h0F, 64'h0, 0, 64'h0000_0000_0000_0087, "LBU 0x0F");
    add(1, 0, 3'b000, 32'h0F, 64'h0, 0, 64'hFFFF_FFFF_FFFF_FF87, "LB 0x0F");
    add(1, 0, 3'b111, 32'h08, 64'h0, 1, 64'h0, "funct3 111 64-bit");
    add(1, 1, 3'b010, 32'h0C, 64'hFFFF_FFFF_A5A5_A5A5, 0, 64'h0, "SW 0x0C 64-bit");
    add(1, 0, 3'b011, 32'h08, 64'h0, 0, 64'hA5A5_A5A5_0FED_CBA9, "LD 0x08 after SW");

    foreach (vecs[i]) run_vec(vecs[i]);

    // Both instances drain once no request follows.
    @(posedge clk);
    #1;
    check("drain a rsp_valid", {63'd0, a_rsp_valid}, 64'd0);
    check("drain b rsp_valid", {63'd0, b_rsp_valid}, 64'd0);

    // Back-pressure: hold rsp_ready low for 3 cycles with a request waiting.
    a_rsp_ready = 1'b0;
    set_a(0, 3'b010, 32'h10, 32'h0);
    @(posedge clk);
    #1;
    set_a(0, 3'b000, 32'h10, 32'h0);
    $display("[TB] bp LW 0x10: valid=%0d rdata=%h", a_rsp_valid, a_rsp_rdata);
    check("bp first valid", {63'd0, a_rsp_valid}, 64'd1);
    check("bp first rdata", {32'd0, a_rsp_rdata}, 64'h8000_00F1);
    for (int i = 0; i < 3; i++) begin
      check("bp req_ready low", {63'd0, a_req_ready}, 64'd0);
      @(posedge clk);
      #1;
      check("bp hold valid", {63'd0, a_rsp_valid}, 64'd1);
      check("bp hold err", {63'd0, a_rsp_err}, 64'd0);
      check("bp hold rdata", {32'd0, a_rsp_rdata}, 64'h8000_00F1);
    end
    a_rsp_ready = 1'b1;
    #1 check("bp release ready", {63'd0, a_req_ready}, 64'd1);
    @(posedge clk);
    #1;
    a_req_valid = 1'b0;
    $display("[TB] bp LB 0x10: valid=%0d rdata=%h", a_rsp_valid, a_rsp_rdata);
    check("bp next valid", {63'd0, a_rsp_valid}, 64'd1);
    check("bp next rdata", {32'd0, a_rsp_rdata}, 64'hFFFF_FFF1);
    @(posedge clk);
    #1;
    check("bp idle", {63'd0, a_rsp_valid}, 64'd0);

    // Reset while a response is pending; a store held during reset must not land.
    a_rsp_ready = 1'b0;
    set_a(0, 3'b010, 32'h20, 32'h0);
    @(posedge clk);
    #1;
    check("rst pre valid", {63'd0, a_rsp_valid}, 64'd1);
    check("rst pre rdata", {32'd0, a_rsp_rdata}, 64'hBEEF_AA44);
    set_a(1, 3'b010, 32'h20, 32'hDEAD_BEEF);
    #1 rst_n = 1'b0;
    #1;
    check("rst mid valid", {63'd0, a_rsp_valid}, 64'd0);
    check("rst mid err", {63'd0, a_rsp_err}, 64'd0);
    check("rst mid rdata", {32'd0, a_rsp_rdata}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0;
    a_rsp_ready = 1'b1;
    rst_n = 1'b1;
    #1 check("rst release ready", {63'd0, a_req_ready}, 64'd1);
    @(posedge clk);
    #1;
    check("rst release valid", {63'd0, a_rsp_valid}, 64'd0);
    set_a(0, 3'b010, 32'h20, 32'h0);
    @(posedge clk);
    #1;
    a_req_valid = 1'b0;
    $display("[TB] post-reset LW 0x20: valid=%0d rdata=%h", a_rsp_valid, a_rsp_rdata);
    check("rst no write valid", {63'd0, a_rsp_valid}, 64'd1);
    check("rst no write rdata", {32'd0, a_rsp_rdata}, 64'hBEEF_AA44);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
